sprite_fetcher: RTL and testbench
=================================

// Module: sprite_fetcher
// PURPOSE
//  Responder side of the sprite fetch handshake. On sprite_fetch it reads the tile row's low/high bitplanes from VRAM.
//  It then merges the 8 object pixels into the object pixel shift register and pulses back sprite_fetch_done.
//  Sits in the PPU between the OAM/sprite evaluator, the VRAM arbiter and the pixel mixer.
// PARAMETERS
//  OBJ_BASE   1'b0   VRAM addr[12]: object tiles always at $8000-$8FFF
// PORTS
//  clk               in   1   system clock; all state on posedge
//  reset             in   1   synchronous, active-high
//  ce                in   1   PPU clock enable; state advances only when ce=1
//  isGBC             in   1   CGB mode: enables VRAM bank and 3-bit palette
//  sprite_fetch      in   1   request from evaluator; held until done is seen
//  sprite_addr       in   11  {tile,row} byte-pair address; valid from 3rd ce of request
//  sprite_attr       in   8   OAM attribute byte; valid with sprite_addr
//  sprite_index      in   4   line slot (0-9) of sprite being fetched
//  sprite_fetch_done out  1   completion; rising edge consumed by evaluator
//  vram_rd           out  1   VRAM read request for current slot
//  vram_addr         out  13  {OBJ_BASE, sprite_addr, plane}
//  vram_bank         out  1   isGBC & sprite_attr[3]
//  vram_data         in   8   read data, valid on 2nd ce of slot
//  line_clear        in   1   start of line: empty object shifter
//  shift             in   1   advance object shifter by one pixel (mixer)
//  busy              out  1   state != IDLE
//  obj_color         out  2   head pixel colour (0 = transparent)
//  obj_palette       out  3   head pixel palette (DMG: {2'b0,attr[4]}; CGB: attr[2:0])
//  obj_prio          out  1   head pixel BG-over-OBJ bit (attr[7])
// BEHAVIOUR
//  Reset: state=IDLE; done, vram_rd, busy = 0; shifter all colour 0; all obj_* = 0.
//  FSM (transitions on ce): IDLE -> OAM0 -> OAM1 -> LO0 -> LO1 -> HI0 -> HI1 -> MERGE -> DONE -> IDLE.
//   IDLE: leave when sprite_fetch=1.
//   OAM0/OAM1: wait while the evaluator reads tile/attr from OAM; no VRAM access.
//   LO0/LO1: vram_rd=1, plane=0. Latch vram_data into lo at LO1.
//   HI0/HI1: vram_rd=1, plane=1. Latch vram_data into hi at HI1.
//   MERGE: one ce; write the merged row into the shifter.
//   DONE: sprite_fetch_done=1, held until sprite_fetch=0, then return to IDLE.
//  Fetch latency: sprite_fetch rise to done rise = 8 ce cycles.
//  sprite_fetch dropping before DONE: abort to IDLE; no merge, done stays 0.
//  Pixel i (0 = leftmost) = {hi[7-i],lo[7-i]}. If attr[5] (X flip): {hi[i],lo[i]}.
//   Vertical flip is already applied in sprite_addr.
//  Merge: slot i is overwritten only if its current colour = 0 (earlier fetch wins, DMG and CGB alike).
//   Palette and prio are written with the colour.
//  Shifter: 8 slots of {color,palette,prio}. On shift (ce=1), slot0 drops out, slots move down, slot7 <= 0.
//   obj_* = slot0, combinational from registers.
//  shift while busy=1 is ignored (mixer must stall). line_clear zeroes all slots and has priority over shift.
//   line_clear during a fetch also aborts the fetch to IDLE.
//  Consecutive fetches at the same X, e.g. IDLE->...->DONE->IDLE->OAM0, are legal and need no idle gap
//   beyond the DONE release.
//  ce=0: all state holds; outputs stable.
// STRUCTURE
//  Shared package gb_ppu_pkg: FSM state encodings, OBJ pixel struct {color[1:0],palette[2:0],prio}, VRAM base constants.
//  One sub-module: obj_shifter. Holds the 8-slot register, merge-if-transparent, shift, clear.
//   The FSM and VRAM addressing stay in sprite_fetcher.
// TESTING
//  1. DMG, attr=8'h00, addr=11'h0A3, lo=8'hF0, hi=8'hCC -> vram_addr 13'h0146 then 13'h0147.
//     done on the 8th ce; pixels 0..7 = 3,3,1,1,2,2,0,0.
//  2. Same data with attr[5]=1 -> pixels 0..7 = 0,0,2,2,1,1,3,3.
//  3. Shifter holds 1,0,1,0,...; fetch row of all colour 2 -> result 1,2,1,2,...; old slots keep their palette.
//  4. CGB, attr=8'h8B -> vram_bank=1, obj_palette=3, obj_prio=1. Same attr with isGBC=0 -> bank=0, palette=0.
//  5. reset asserted in HI0 -> next cycle IDLE, done=0, shifter empty. sprite_fetch drop in LO1 -> IDLE, no merge.
//  6. Toggle ce 1-of-4 and assert shift while busy -> identical results to ce=1; no shift taken while busy.

Source files
------------

// File: rtl/gb_ppu_pkg.sv
// rtl/gb_ppu_pkg.sv - shared PPU object-fetch types, state encodings and row decode
package gb_ppu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OAM0,
        ST_OAM1,
        ST_LO0,
        ST_LO1,
        ST_HI0,
        ST_HI1,
        ST_MERGE,
        ST_DONE
    } fetch_state_t;

    typedef struct packed {
        logic [1:0] color;
        logic [2:0] palette;
        logic       prio;
    } obj_pix_t;

    localparam int OBJ_PIX_W  = $bits(obj_pix_t);
    localparam int OBJ_SLOTS  = 8;

    typedef obj_pix_t [OBJ_SLOTS-1:0] obj_row_t;

    // Object tiles live in $8000-$8FFF, so VRAM addr[12] is zero.
    localparam logic OBJ_BASE_DEFAULT = 1'b0;

    // Element 0 is the leftmost pixel; X flip mirrors the bitplane order.
    function automatic obj_row_t decode_row(
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic [7:0] attr,
        input logic       gbc
    );
        obj_row_t   row;
        logic [2:0] b;
        for (int i = 0; i < OBJ_SLOTS; i++) begin
            b = attr[5] ? 3'(i) : 3'(7 - i);
            row[i].color   = {hi[b], lo[b]};
            row[i].palette = gbc ? attr[2:0] : {2'b00, attr[4]};
            row[i].prio    = attr[7];
        end
        return row;
    endfunction

endpackage

// File: rtl/obj_shifter.sv
// rtl/obj_shifter.sv - 8-slot object pixel shifter with merge-if-transparent
module obj_shifter
    import gb_ppu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     ce,
    input  logic     clear,
    input  logic     merge,
    input  logic     shift,
    input  obj_row_t row,
    output obj_pix_t head
);

    obj_row_t slots;

    always_ff @(posedge clk) begin
        if (reset) begin
            slots <= '0;
        end else if (ce) begin
            if (clear) begin
                slots <= '0;
            end else if (merge) begin
                // An opaque pixel from an earlier sprite always wins.
                for (int i = 0; i < OBJ_SLOTS; i++) begin
                    if (slots[i].color == 2'd0) begin
                        slots[i] <= row[i];
                    end
                end
            end else if (shift) begin
                slots <= {OBJ_PIX_W'(0), slots[OBJ_SLOTS-1:1]};
            end
        end
    end

    assign head = slots[0];

endmodule

// File: rtl/sprite_fetcher.sv
// rtl/sprite_fetcher.sv - sprite tile-row fetch FSM feeding the object pixel shifter
module sprite_fetcher
    import gb_ppu_pkg::*;
#(
    parameter logic OBJ_BASE = OBJ_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        isGBC,
    input  logic        sprite_fetch,
    input  logic [10:0] sprite_addr,
    input  logic [7:0]  sprite_attr,
    input  logic [3:0]  sprite_index,
    output logic        sprite_fetch_done,
    output logic        vram_rd,
    output logic [12:0] vram_addr,
    output logic        vram_bank,
    input  logic [7:0]  vram_data,
    input  logic        line_clear,
    input  logic        shift,
    output logic        busy,
    output logic [1:0]  obj_color,
    output logic [2:0]  obj_palette,
    output logic        obj_prio
);

    fetch_state_t state;
    logic         plane;
    logic [7:0]   lo;
    logic [7:0]   hi;
    logic         merge_en;
    logic         shift_en;
    obj_pix_t     head;
    logic         unused_inputs;

    assign vram_addr     = {OBJ_BASE, sprite_addr, plane};
    assign vram_bank     = isGBC & sprite_attr[3];
    assign merge_en      = (state == ST_MERGE) && sprite_fetch && !line_clear;
    // The mixer is expected to stall while a fetch is in flight.
    assign shift_en      = shift && !busy;
    assign unused_inputs = ^{sprite_index, sprite_attr[6]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            sprite_fetch_done <= 1'b0;
            vram_rd           <= 1'b0;
            busy              <= 1'b0;
            plane             <= 1'b0;
            lo                <= 8'h00;
            hi                <= 8'h00;
        end else if (ce) begin
            if (line_clear || !sprite_fetch) begin
                // Covers both the abort path and the normal DONE release.
                state             <= ST_IDLE;
                sprite_fetch_done <= 1'b0;
                vram_rd           <= 1'b0;
                busy              <= 1'b0;
                plane             <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_OAM0;
                        busy  <= 1'b1;
                    end
                    ST_OAM0: state <= ST_OAM1;
                    ST_OAM1: begin
                        state   <= ST_LO0;
                        vram_rd <= 1'b1;
                        plane   <= 1'b0;
                    end
                    ST_LO0:  state <= ST_LO1;
                    ST_LO1: begin
                        lo    <= vram_data;
                        plane <= 1'b1;
                        state <= ST_HI0;
                    end
                    ST_HI0:  state <= ST_HI1;
                    ST_HI1: begin
                        hi      <= vram_data;
                        vram_rd <= 1'b0;
                        state   <= ST_MERGE;
                    end
                    ST_MERGE: begin
                        state             <= ST_DONE;
                        sprite_fetch_done <= 1'b1;
                    end
                    ST_DONE: state <= ST_DONE;
                    default: begin
                        state             <= ST_IDLE;
                        sprite_fetch_done <= 1'b0;
                        vram_rd           <= 1'b0;
                        busy              <= 1'b0;
                    end
                endcase
            end
        end
    end

    obj_shifter u_obj_shifter (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .clear (line_clear),
        .merge (merge_en),
        .shift (shift_en),
        .row   (decode_row(lo, hi, sprite_attr, isGBC)),
        .head  (head)
    );

    assign obj_color   = head.color;
    assign obj_palette = head.palette;
    assign obj_prio    = head.prio;

endmodule

// File: tb/tb_sprite_fetcher.sv
// tb/tb_sprite_fetcher.sv - self-checking bench for sprite_fetcher
module tb_sprite_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        isGBC = 1'b0;
    logic        sprite_fetch = 1'b0;
    logic [10:0] sprite_addr = '0;
    logic [7:0]  sprite_attr = '0;
    logic [3:0]  sprite_index = '0;
    logic [7:0]  vram_data = '0;
    logic        line_clear = 1'b0;
    logic        shift = 1'b0;
    logic        sprite_fetch_done;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic        vram_bank;
    logic        busy;
    logic [1:0]  obj_color;
    logic [2:0]  obj_palette;
    logic        obj_prio;

    sprite_fetcher dut (
        .clk               (clk),
        .reset             (reset),
        .ce                (ce),
        .isGBC             (isGBC),
        .sprite_fetch      (sprite_fetch),
        .sprite_addr       (sprite_addr),
        .sprite_attr       (sprite_attr),
        .sprite_index      (sprite_index),
        .sprite_fetch_done (sprite_fetch_done),
        .vram_rd           (vram_rd),
        .vram_addr         (vram_addr),
        .vram_bank         (vram_bank),
        .vram_data         (vram_data),
        .line_clear        (line_clear),
        .shift             (shift),
        .busy              (busy),
        .obj_color         (obj_color),
        .obj_palette       (obj_palette),
        .obj_prio          (obj_prio)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [8192];

    // Model: m_cnt counts ce edges since the request was accepted (8 = done held).
    int m_cnt = 0;
    int mc[8];
    int mp[8];
    int mr[8];
    bit m_valid = 0;

    int rc[8];
    int rp[8];
    int rr[8];

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            mc[i] = 0; mp[i] = 0; mr[i] = 0;
        end
    endfunction

    function automatic void model_shift();
        for (int i = 0; i < 7; i++) begin
            mc[i] = mc[i+1]; mp[i] = mp[i+1]; mr[i] = mr[i+1];
        end
        mc[7] = 0; mp[7] = 0; mr[7] = 0;
    endfunction

    function automatic void model_merge();
        logic [7:0] lo, hi;
        int b;
        lo = mem[{1'b0, sprite_addr, 1'b0}];
        hi = mem[{1'b0, sprite_addr, 1'b1}];
        for (int i = 0; i < 8; i++) begin
            b = sprite_attr[5] ? i : 7 - i;
            if (mc[i] == 0) begin
                mc[i] = 2 * hi[b] + lo[b];
                mp[i] = isGBC ? int'(sprite_attr[2:0]) : int'(sprite_attr[4]);
                mr[i] = sprite_attr[7];
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0;
            model_clear();
            m_valid = 1;
        end else if (ce) begin
            if (line_clear) begin
                model_clear();
                m_cnt = 0;
            end else begin
                if (m_cnt == 0 && shift) model_shift();
                if (!sprite_fetch) begin
                    m_cnt = 0;
                end else begin
                    if (m_cnt == 7) model_merge();
                    if (m_cnt < 8) m_cnt++;
                end
            end
        end
    end

    // VRAM: real data only during the second ce of each read slot, noise otherwise.
    always @(posedge clk) begin
        #1;
        if (m_cnt == 4 || m_cnt == 6)
            vram_data = mem[{1'b0, sprite_addr, (m_cnt == 6)}];
        else
            vram_data = 8'($urandom);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, int'(m_cnt != 0));
            chk("done", sprite_fetch_done, int'(m_cnt == 8));
            chk("vram_rd", vram_rd, int'(m_cnt >= 3 && m_cnt <= 6));
            if (m_cnt >= 3 && m_cnt <= 6)
                chk("vram_addr", vram_addr, int'({1'b0, sprite_addr, (m_cnt >= 5)}));
            chk("vram_bank", vram_bank, int'(isGBC & sprite_attr[3]));
            chk("obj_color", obj_color, mc[0]);
            chk("obj_palette", obj_palette, mp[0]);
            chk("obj_prio", obj_prio, mr[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit ce_for(input int pat, input int k);
        if (pat == 0) return 1'b1;
        if (pat == 1) return (k % 4) == 0;
        return $urandom_range(0, 2) != 0;
    endfunction

    task automatic clear_line();
        ce = 1'b1; line_clear = 1'b1; shift = 1'b0;
        tick();
        line_clear = 1'b0;
    endtask

    task automatic fetch(input logic [10:0] a, input logic [7:0] at, input logic gbc,
                         input int pat, input bit sh, output int lat,
                         output logic [12:0] a_first, output logic [12:0] a_last,
                         output logic bank_seen);
        bit got = 0;
        sprite_addr = a; sprite_attr = at; isGBC = gbc; sprite_fetch = 1'b1;
        lat = 0; a_first = '0; a_last = '0; bank_seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            ce = ce_for(pat, k);
            shift = sh;
            tick();
            if (ce) lat++;
            if (vram_rd) begin
                if (!got) a_first = vram_addr;
                got = 1;
                a_last = vram_addr;
                bank_seen = vram_bank;
            end
            if (sprite_fetch_done) break;
        end
        if (!sprite_fetch_done) chk("fetch_timeout", 0, 1);
        sprite_fetch = 1'b0; shift = 1'b0; ce = 1'b1;
        tick();
    endtask

    task automatic read_row();
        for (int i = 0; i < 8; i++) begin
            rc[i] = obj_color; rp[i] = obj_palette; rr[i] = obj_prio;
            ce = 1'b1; shift = 1'b1;
            tick();
        end
        shift = 1'b0;
    endtask

    initial begin
        int lat;
        logic [12:0] af, al;
        logic bk;
        int exp1[8] = '{3, 3, 1, 1, 2, 2, 0, 0};
        int exp2[8] = '{0, 0, 2, 2, 1, 1, 3, 3};
        int kab, mode, pat, cecnt;

        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

        reset = 1'b1; ce = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", sprite_fetch_done, 0);
        chk("reset_vram_rd", vram_rd, 0);
        chk("reset_color", obj_color, 0);

        // Basic DMG fetch, no flip.
        mem[13'h0146] = 8'hF0; mem[13'h0147] = 8'hCC;
        clear_line();
        fetch(11'h0A3, 8'h00, 1'b0, 0, 1'b0, lat, af, al, bk);
        chk("t1_latency", lat, 8);
        chk("t1_addr_lo", af, 13'h0146);
        chk("t1_addr_hi", al, 13'h0147);
        read_row();
        for (int i = 0; i < 8; i++) chk($sformatf("t1_pix%0d", i), rc[i], exp1[i]);

        // X flip.
        clear_line();
        fetch(11'h0A3, 8'h20, 1'b0, 0, 1'b0, lat, af, al, bk);
        read_row();
        for (int i = 0; i < 8; i++) chk($sformatf("t2_pix%0d", i), rc[i], exp2[i]);

        // Merge only into transparent slots; existing palette kept.
        mem[13'h00AA] = 8'hAA; mem[13'h00AB] = 8'h00;
        mem[13'h00AC] = 8'h00; mem[13'h00AD] = 8'hFF;
        clear_line();
        fetch(11'h055, 8'h10, 1'b0, 0, 1'b0, lat, af, al, bk);
        fetch(11'h056, 8'h00, 1'b0, 0, 1'b0, lat, af, al, bk);
        read_row();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_col%0d", i), rc[i], (i % 2 == 0) ? 1 : 2);
            chk($sformatf("t3_pal%0d", i), rp[i], (i % 2 == 0) ? 1 : 0);
        end

        // CGB bank/palette/prio versus DMG with the same attribute.
        mem[13'h0200] = 8'hFF; mem[13'h0201] = 8'h00;
        clear_line();
        fetch(11'h100, 8'h8B, 1'b1, 0, 1'b0, lat, af, al, bk);
        chk("t4_cgb_bank", bk, 1);
        chk("t4_cgb_pal", obj_palette, 3);
        chk("t4_cgb_prio", obj_prio, 1);
        clear_line();
        fetch(11'h100, 8'h8B, 1'b0, 0, 1'b0, lat, af, al, bk);
        chk("t4_dmg_bank", bk, 0);
        chk("t4_dmg_pal", obj_palette, 0);
        chk("t4_dmg_prio", obj_prio, 1);

        // Reset in HI0 empties everything.
        sprite_addr = 11'h100; sprite_attr = 8'h00; isGBC = 1'b0;
        sprite_fetch = 1'b1; ce = 1'b1;
        repeat (5) tick();
        chk("t5_hi0_rd", vram_rd, 1);
        chk("t5_hi0_addr", vram_addr, 13'h0201);
        reset = 1'b1; sprite_fetch = 1'b0;
        tick();
        reset = 1'b0;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", sprite_fetch_done, 0);
        chk("t5_rst_color", obj_color, 0);

        // Request dropped in LO1: no merge.
        fetch(11'h0A3, 8'h00, 1'b0, 0, 1'b0, lat, af, al, bk);
        sprite_addr = 11'h100; sprite_fetch = 1'b1; ce = 1'b1;
        repeat (4) tick();
        sprite_fetch = 1'b0;
        tick();
        chk("t5_abort_busy", busy, 0);
        repeat (10) tick();
        read_row();
        for (int i = 0; i < 8; i++) chk($sformatf("t5_pix%0d", i), rc[i], exp1[i]);

        // Sparse ce and shift held while busy.
        clear_line();
        fetch(11'h0A3, 8'h00, 1'b0, 1, 1'b1, lat, af, al, bk);
        chk("t6_latency", lat, 8);
        read_row();
        for (int i = 0; i < 8; i++) chk($sformatf("t6_pix%0d", i), rc[i], exp1[i]);

        // Randomized traffic against the model.
        for (int r = 0; r < 120; r++) begin
            repeat ($urandom_range(0, 3)) begin
                ce = $urandom_range(0, 3) != 0;
                shift = $urandom_range(0, 1);
                line_clear = ($urandom_range(0, 15) == 0);
                tick();
            end
            line_clear = 1'b0;
            sprite_addr = 11'($urandom);
            sprite_attr = 8'($urandom);
            isGBC = $urandom_range(0, 1);
            pat = $urandom_range(0, 2);
            mode = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 2);
            kab = $urandom_range(1, 7);
            cecnt = 0;
            sprite_fetch = 1'b1;
            for (int k = 0; k < 400; k++) begin
                ce = ce_for(pat, k);
                shift = $urandom_range(0, 1);
                line_clear = 1'b0;
                if (mode != 0 && cecnt == kab && ce) begin
                    if (mode == 1) sprite_fetch = 1'b0;
                    else line_clear = 1'b1;
                end
                tick();
                if (ce) cecnt++;
                if (mode != 0 && cecnt > kab) break;
                if (sprite_fetch_done) break;
            end
            line_clear = 1'b0;
            if (mode == 0 && !sprite_fetch_done) chk("rand_timeout", 0, 1);
            repeat ($urandom_range(0, 2)) begin
                ce = $urandom_range(0, 1);
                tick();
            end
            sprite_fetch = 1'b0;
        end
        ce = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
